ha_response_checker: RTL and testbench
======================================

Name: ha_response_checker

Overview:
- Self-checking response-analyzer end of the half-adder test flow.
- Drives the exhaustive 2-bit pattern sequence into a half-adder DUT and samples the DUT's sum/carry after a settle window.
- Compares each sample against golden half-adder values, counts mismatches, records the first failing pattern and reports pass/fail.
- Sits beside the DUT in BIST-style on-chip or bench checking, replacing manual waveform inspection of the 4-pattern sweep.

Parameters:
- SETTLE_CYCLES, 1, cycles each pattern is held before its response is sampled; legal range 1..255.
- ERR_W, 3, width of the mismatch counter; minimum 3.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle request to run a full sweep; sampled only in IDLE or DONE.
- pat_a  output  1  stimulus to DUT input a.
- pat_b  output  1  stimulus to DUT input b.
- dut_sum  input  1  DUT sum response.
- dut_carry  input  1  DUT carry response.
- busy  output  1  high while the sweep is in progress.
- done  output  1  high from sweep completion until the next accepted start or reset.
- pass  output  1  valid when done=1; 1 iff err_count==0.
- err_count  output  ERR_W  mismatches in the current/last sweep; saturates at all-ones.
- first_fail_idx  output  2  pattern index {a,b} of the first mismatch; valid when fail_seen=1.
- fail_seen  output  1  at least one mismatch recorded this sweep.
- signature  output  8  MISR response signature (see Optional Feature).

Behaviour:
- Reset (rst=1 at a clock edge), regardless of state including mid-sweep: state=IDLE; pat_a=pat_b=0, busy=0, done=0, pass=0, err_count=0, first_fail_idx=0, fail_seen=0, signature=0x00, pattern index=0, settle counter=0.
- States: IDLE, APPLY, DONE.
- IDLE or DONE, start=1 at edge E0:
  - Go to APPLY; idx=0; settle counter=0; busy=1; done=0; pass=0.
  - Clear err_count, fail_seen, first_fail_idx; seed signature=0x00.
- start=0 in IDLE/DONE: hold all outputs.
- start while in APPLY: ignored, no restart.
- APPLY:
  - Outputs are registered: {pat_a,pat_b}=idx from E0 onward.
  - Each pattern is held SETTLE_CYCLES cycles.
  - At the edge where the settle counter reaches SETTLE_CYCLES-1, sample dut_sum/dut_carry.
  - Expected values: sum=a^b, carry=a&b.
  - On mismatch in either bit: err_count+1, saturating.
  - If fail_seen was 0 at that edge: first_fail_idx=idx, fail_seen=1.
  - Same edge: update MISR; idx+1; settle counter=0.
  - Pattern order: 00, 01, 10, 11.
- Completion: the sample edge for idx=3 moves to DONE.
  - busy=0; done=1; pass=(final err_count==0).
  - Sample at that edge is included in the final count.
  - pat_a/pat_b return to 0 in DONE.
- Latency: done rises exactly 4*SETTLE_CYCLES cycles after E0, i.e. it is visible after edge E0+4*SETTLE_CYCLES.
- DUT path is combinational; the sampled response must correspond to the pattern driven since the pattern's first cycle.
- Simultaneous rst and start: rst wins.

Optional Feature:
- Macro: HA_CHECK_MISR_EN.
- Defined:
  - 8-bit MISR updates on each sample edge: fb=sig[7]; sig_next = (sig<<1) ^ (fb ? 0x1D : 0x00) ^ {6'b0, dut_carry, dut_sum}.
  - Seeded 0x00 on accepted start.
  - Golden signature for a correct DUT is 0x04.
- Not defined:
  - MISR logic is absent.
  - signature is constant 0x00.
  - All other behaviour is identical.

Test Plan:
- Reset then idle 5 cycles -> busy=0, done=0, pass=0, err_count=0, fail_seen=0, pat_a=pat_b=0, signature=0x00.
- Correct half adder, SETTLE_CYCLES=1, start pulse -> pats 00,01,10,11 on consecutive cycles; done after 4 cycles; pass=1, err_count=0, fail_seen=0; signature=0x04 with HA_CHECK_MISR_EN.
- DUT sum stuck-at-0 -> err_count=2, first_fail_idx=1, fail_seen=1, pass=0; signature=0x02 with MISR.
- SETTLE_CYCLES=3, correct DUT -> each pattern held 3 cycles; done exactly 12 cycles after start edge; pass=1.
- start re-pulsed at cycle 2 of sweep -> ignored; done still at 4*SETTLE_CYCLES. start in DONE -> new sweep with cleared counters.
- rst asserted during idx=2 with a prior mismatch -> next cycle all outputs at reset values, state IDLE; subsequent start runs a clean sweep.

Source files
------------

// File: rtl/ha_response_checker.sv
// Half-adder response checker: sweeps {a,b}=00..11, samples the DUT after SETTLE_CYCLES, counts mismatches.
// Optional 8-bit response MISR is enabled by defining HA_CHECK_MISR_EN; otherwise signature stays 0x00.
module ha_response_checker #(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W         = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             pat_a,
  output logic             pat_b,
  input  logic             dut_sum,
  input  logic             dut_carry,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       first_fail_idx,
  output logic             fail_seen,
  output logic [7:0]       signature
);

  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

  localparam logic [7:0] LAST_CNT = 8'(SETTLE_CYCLES - 1);

  state_t           state, state_nxt;
  logic [1:0]       idx, idx_nxt;
  logic [7:0]       cnt, cnt_nxt;
  logic             pat_a_nxt, pat_b_nxt;
  logic             busy_nxt, done_nxt, pass_nxt, fail_seen_nxt;
  logic [ERR_W-1:0] err_nxt, err_upd;
  logic [1:0]       ffi_nxt;
  logic [7:0]       sig_nxt, sig_upd;
  logic             sample, mismatch;

  assign sample   = (state == APPLY) && (cnt == LAST_CNT);
  assign mismatch = (dut_sum != (idx[1] ^ idx[0])) || (dut_carry != (idx[1] & idx[0]));
  assign err_upd  = !mismatch ? err_count :
                    (&err_count) ? err_count : err_count + ERR_W'(1);

`ifdef HA_CHECK_MISR_EN
  assign sig_upd = {signature[6:0], 1'b0} ^ (signature[7] ? 8'h1D : 8'h00)
                 ^ {6'b0, dut_carry, dut_sum};
`else
  assign sig_upd = 8'h00;
`endif

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    cnt_nxt       = cnt;
    pat_a_nxt     = pat_a;
    pat_b_nxt     = pat_b;
    busy_nxt      = busy;
    done_nxt      = done;
    pass_nxt      = pass;
    err_nxt       = err_count;
    ffi_nxt       = first_fail_idx;
    fail_seen_nxt = fail_seen;
    sig_nxt       = signature;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt     = APPLY;
          idx_nxt       = 2'd0;
          cnt_nxt       = 8'd0;
          pat_a_nxt     = 1'b0;
          pat_b_nxt     = 1'b0;
          busy_nxt      = 1'b1;
          done_nxt      = 1'b0;
          pass_nxt      = 1'b0;
          err_nxt       = '0;
          ffi_nxt       = 2'd0;
          fail_seen_nxt = 1'b0;
          sig_nxt       = 8'h00;
        end
      end
      APPLY: begin
        if (sample) begin
          err_nxt = err_upd;
          sig_nxt = sig_upd;
          cnt_nxt = 8'd0;
          if (mismatch && !fail_seen) begin
            fail_seen_nxt = 1'b1;
            ffi_nxt       = idx;
          end
          if (idx == 2'd3) begin
            // The last pattern's sample is already folded into err_upd here.
            state_nxt = DONE;
            idx_nxt   = 2'd0;
            pat_a_nxt = 1'b0;
            pat_b_nxt = 1'b0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            pass_nxt  = (err_upd == '0);
          end else begin
            idx_nxt   = idx + 2'd1;
            pat_a_nxt = idx_nxt[1];
            pat_b_nxt = idx_nxt[0];
          end
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= 2'd0;
      cnt            <= 8'd0;
      pat_a          <= 1'b0;
      pat_b          <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_fail_idx <= 2'd0;
      fail_seen      <= 1'b0;
      signature      <= 8'h00;
    end else begin
      state          <= state_nxt;
      idx            <= idx_nxt;
      cnt            <= cnt_nxt;
      pat_a          <= pat_a_nxt;
      pat_b          <= pat_b_nxt;
      busy           <= busy_nxt;
      done           <= done_nxt;
      pass           <= pass_nxt;
      err_count      <= err_nxt;
      first_fail_idx <= ffi_nxt;
      fail_seen      <= fail_seen_nxt;
      signature      <= sig_nxt;
    end
  end

endmodule

// File: tb/tb_ha_response_checker.sv
// Bench for ha_response_checker: two instances (settle 1 and 3) driving a fault-injectable half-adder model.
module tb_ha_response_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start1 = 1'b0, start3 = 1'b0;
  logic [1:0] mask [4];
  int total = 0, bad = 0;
  int sel = 0;

  always #5 clk = ~clk;

  logic       pa1, pb1, sum1, car1, busy1, done1, pass1, fs1;
  logic [2:0] err1;
  logic [1:0] ffi1;
  logic [7:0] sig1;
  logic       pa3, pb3, sum3, car3, busy3, done3, pass3, fs3;
  logic [2:0] err3;
  logic [1:0] ffi3;
  logic [7:0] sig3;

  // Half adder with a per-pattern response flip mask {carry,sum}.
  assign {car1, sum1} = {pa1 & pb1, pa1 ^ pb1} ^ mask[{pa1, pb1}];
  assign {car3, sum3} = {pa3 & pb3, pa3 ^ pb3} ^ mask[{pa3, pb3}];

  ha_response_checker #(.SETTLE_CYCLES(1), .ERR_W(3)) u_s1 (
    .clk(clk), .rst(rst), .start(start1), .pat_a(pa1), .pat_b(pb1),
    .dut_sum(sum1), .dut_carry(car1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail_idx(ffi1), .fail_seen(fs1), .signature(sig1));

  ha_response_checker #(.SETTLE_CYCLES(3), .ERR_W(3)) u_s3 (
    .clk(clk), .rst(rst), .start(start3), .pat_a(pa3), .pat_b(pb3),
    .dut_sum(sum3), .dut_carry(car3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .first_fail_idx(ffi3), .fail_seen(fs3), .signature(sig3));

  logic [1:0] o_pat, o_ffi;
  logic       o_busy, o_done, o_pass, o_fs;
  logic [2:0] o_err;
  logic [7:0] o_sig;
  always_comb begin
    if (sel == 0) begin
      o_pat = {pa1, pb1}; o_busy = busy1; o_done = done1; o_pass = pass1;
      o_err = err1; o_ffi = ffi1; o_fs = fs1; o_sig = sig1;
    end else begin
      o_pat = {pa3, pb3}; o_busy = busy3; o_done = done3; o_pass = pass3;
      o_err = err3; o_ffi = ffi3; o_fs = fs3; o_sig = sig3;
    end
  end

  typedef struct {
    logic [7:0] m;      // mask[i] = m[2i+1:2i]
    int         err;
    int         first;
    int         fs;
    int         ps;
    logic [7:0] sig;    // MISR signature when the MISR is built in
  } vec_t;

  function automatic logic [7:0] sig_exp(input logic [7:0] s);
`ifdef HA_CHECK_MISR_EN
    return s;
`else
    return 8'h00;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s sel=%0d actual=%0d required=%0d", name, sel, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mask(input logic [7:0] m);
    for (int i = 0; i < 4; i++) mask[i] = m[2*i +: 2];
  endtask

  task automatic set_start(input logic v);
    if (sel == 0) start1 = v; else start3 = v;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_pass"}, o_pass, 0);
    chk({tag, "_err"}, o_err, 0);
    chk({tag, "_fs"}, o_fs, 0);
    chk({tag, "_ffi"}, o_ffi, 0);
    chk({tag, "_pat"}, o_pat, 0);
    chk({tag, "_sig"}, o_sig, 0);
  endtask

  // Runs one sweep from start; tracks pattern timing and done latency, then checks results.
  task automatic run_sweep(input bit repulse, input int e_err, input int e_first,
                           input int e_fs, input int e_pass, input logic [7:0] e_sig);
    int s = (sel == 0) ? 1 : 3;
    int timing_bad = 0;
    set_start(1'b1);
    tick();
    set_start(1'b0);
    for (int k = 0; k < 4 * s; k++) begin
      if (o_pat != 2'(k / s) || o_done != 1'b0 || o_busy != 1'b1) timing_bad++;
      if (repulse && k == 1) begin
        set_start(1'b1);
        tick();
        set_start(1'b0);
      end else begin
        tick();
      end
    end
    chk("sweep_timing", timing_bad, 0);
    chk("done_latency", o_done, 1);
    chk("busy_end", o_busy, 0);
    chk("pat_end", o_pat, 0);
    chk("err_count", o_err, e_err);
    chk("fail_seen", o_fs, e_fs);
    if (e_fs != 0) chk("first_fail", o_ffi, e_first);
    chk("pass", o_pass, e_pass);
    chk("signature", o_sig, sig_exp(e_sig));
  endtask

  // Reference: per-pattern responses derived straight from the mask.
  task automatic model(input logic [7:0] m, output int e_err, output int e_first,
                       output int e_fs, output int e_pass, output logic [7:0] e_sig);
    int s = 0;
    e_err = 0; e_first = 0; e_fs = 0;
    for (int i = 0; i < 4; i++) begin
      int a = i / 2, b = i % 2;
      int golden = (a * b) * 2 + ((a + b) % 2);
      int resp = golden ^ int'(m[2*i +: 2]);
      if (m[2*i +: 2] != 2'b00) begin
        if (e_fs == 0) e_first = i;
        e_fs = 1;
        e_err++;
      end
      s = ((s * 2) % 256) ^ ((s >= 128) ? 29 : 0) ^ resp;
    end
    if (e_err > 7) e_err = 7;
    e_pass = (e_err == 0) ? 1 : 0;
    e_sig = 8'(s);
  endtask

  vec_t tbl [5];

  initial begin
    int e_err, e_first, e_fs, e_pass;
    logic [7:0] e_sig, m;

    tbl[0] = '{m: 8'h00, err: 0, first: 0, fs: 0, ps: 1, sig: 8'h04};
    tbl[1] = '{m: 8'h14, err: 2, first: 1, fs: 1, ps: 0, sig: 8'h02};
    tbl[2] = '{m: 8'h2A, err: 3, first: 0, fs: 1, ps: 0, sig: 8'h18};
    tbl[3] = '{m: 8'hC0, err: 1, first: 3, fs: 1, ps: 0, sig: 8'h07};
    tbl[4] = '{m: 8'h00, err: 0, first: 0, fs: 0, ps: 1, sig: 8'h04};

    set_mask(8'h00);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    repeat (5) tick();
    sel = 0; chk_reset_state("rst_s1");
    sel = 1; chk_reset_state("rst_s3");

    // Table on both settle settings; back-to-back sweeps also exercise start from DONE.
    for (int si = 0; si < 2; si++) begin
      sel = si;
      for (int i = 0; i < 5; i++) begin
        set_mask(tbl[i].m);
        run_sweep(i == 4, tbl[i].err, tbl[i].first, tbl[i].fs, tbl[i].ps, tbl[i].sig);
      end
    end

    // Reset mid-sweep at idx=2 after a mismatch has already been recorded.
    sel = 0;
    set_mask(8'h14);
    set_start(1'b1); tick(); set_start(1'b0);
    tick(); tick();
    chk("mid_pat", o_pat, 2);
    chk("mid_fs", o_fs, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk_reset_state("mid_rst");
    tick();
    chk("mid_idle", o_busy, 0);
    set_mask(8'h00);
    run_sweep(1'b0, 0, 0, 0, 1, 8'h04);

    // Simultaneous rst and start: reset wins.
    rst = 1'b1; set_start(1'b1); tick(); rst = 1'b0; set_start(1'b0);
    chk_reset_state("rst_start");

    // Random fault masks against the reference model.
    for (int r = 0; r < 24; r++) begin
      sel = int'($urandom_range(0, 1));
      m = 8'($urandom);
      if ($urandom_range(0, 3) == 0) m = 8'h00;
      set_mask(m);
      model(m, e_err, e_first, e_fs, e_pass, e_sig);
      run_sweep($urandom_range(0, 3) == 0, e_err, e_first, e_fs, e_pass, e_sig);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
